switch_box_config_loader: RTL and testbench

Configuration sequencer for the tile array. Accepts a stream of 32-bit configuration packets over a valid/ready handshake and writes each payload word into one tile's 32-bit switch-box configuration register. It does this by broadcasting `config_data` and pulsing that tile's one-hot `config_en` for one cycle. It sits between the off-fabric configuration port and the `config_data`/`config_en` inputs of every switch box.

---
 rtl/switch_box_config_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_switch_box_config_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/switch_box_config_loader.sv
// Switch-box configuration sequencer: unpacks header/payload packets into one-hot tile writes.
// Optional trailing-checksum word per packet is enabled by defining CFG_CHECKSUM_EN.
module switch_box_config_loader #(
   parameter int NUM_TILES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          cfg_in_data,
   input  logic                 cfg_in_valid,
   output logic                 cfg_in_ready,
   input  logic                 err_clear,
   output logic [31:0]          config_data,
   output logic [NUM_TILES-1:0] config_en,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           err_code
);

   localparam logic [7:0]           MAGIC      = 8'hC5;
   localparam logic [8:0]           TILE_LIMIT = 9'(NUM_TILES);
   localparam logic [NUM_TILES-1:0] EN_ONE     = NUM_TILES'(1'b1);

   localparam logic [1:0] CODE_NONE  = 2'd0;
   localparam logic [1:0] CODE_MAGIC = 2'd1;
   localparam logic [1:0] CODE_RANGE = 2'd2;
`ifdef CFG_CHECKSUM_EN
   localparam logic [1:0] CODE_CSUM  = 2'd3;
`endif

`ifdef CFG_CHECKSUM_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_ERROR   = 2'd3
   } state_t;
`endif

   state_t                state_q, state_d;
   logic [8:0]            tile_ptr_q, tile_ptr_d;
   logic [7:0]            remaining_q, remaining_d;
   logic                  ready_q, ready_d;
   logic [31:0]           config_data_q, config_data_d;
   logic [NUM_TILES-1:0]  config_en_q, config_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [1:0]            err_code_q, err_code_d;
`ifdef CFG_CHECKSUM_EN
   logic [31:0]           csum_q, csum_d;
`endif

   logic                  xfer_s;
   logic                  word_err_s;
   logic [7:0]            hdr_magic_s;
   logic [7:0]            hdr_first_s;
   logic [7:0]            hdr_count_s;

   assign xfer_s      = cfg_in_valid & ready_q;
   assign hdr_magic_s = cfg_in_data[31:24];
   assign hdr_first_s = cfg_in_data[15:8];
   assign hdr_count_s = cfg_in_data[7:0];

   // Next-state and next-output computation for the packet sequencer.
   always_comb begin
      state_d       = state_q;
      tile_ptr_d    = tile_ptr_q;
      remaining_d   = remaining_q;
      config_data_d = config_data_q;
      config_en_d   = '0;
      done_d        = 1'b0;
      error_d       = error_q;
      err_code_d    = err_code_q;
      word_err_s    = 1'b0;
`ifdef CFG_CHECKSUM_EN
      csum_d        = csum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (xfer_s) begin
`ifdef CFG_CHECKSUM_EN
               csum_d = cfg_in_data;
`endif
               if (hdr_magic_s != MAGIC) begin
                  state_d    = ST_ERROR;
                  error_d    = 1'b1;
                  err_code_d = CODE_MAGIC;
               end else if (hdr_count_s == 8'd0) begin
`ifdef CFG_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  tile_ptr_d  = {1'b0, hdr_first_s};
                  remaining_d = hdr_count_s;
                  state_d     = ST_PAYLOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_PAYLOAD: begin
            if (xfer_s) begin
`ifdef CFG_CHECKSUM_EN
               csum_d = csum_q ^ cfg_in_data;
`endif
               word_err_s = (tile_ptr_q >= TILE_LIMIT);
               if (word_err_s) begin
                  error_d    = 1'b1;
                  err_code_d = CODE_RANGE;
               end else begin
                  config_data_d = cfg_in_data;
                  config_en_d   = EN_ONE << tile_ptr_q;
               end
               // Pointer is 9 bits so 255+1 lands on 256 (out of range) instead of wrapping.
               tile_ptr_d  = tile_ptr_q + 9'd1;
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
`ifdef CFG_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  if (error_q | word_err_s) begin
                     state_d = ST_ERROR;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
`endif
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end else begin
               state_d = ST_PAYLOAD;
            end
         end

`ifdef CFG_CHECKSUM_EN
         ST_CHECK: begin
            if (xfer_s) begin
               if (cfg_in_data != csum_q) begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
                  // An earlier range error keeps its code.
                  if (error_q) begin
                     err_code_d = err_code_q;
                  end else begin
                     err_code_d = CODE_CSUM;
                  end
               end else if (error_q) begin
                  state_d = ST_ERROR;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = ST_CHECK;
            end
         end
`endif

         ST_ERROR: begin
            if (err_clear) begin
               state_d    = ST_IDLE;
               error_d    = 1'b0;
               err_code_d = CODE_NONE;
            end else begin
               state_d = ST_ERROR;
            end
         end

         default: begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            err_code_d = err_code_q;
         end
      endcase

      ready_d = (state_d != ST_ERROR);
`ifdef CFG_CHECKSUM_EN
      busy_d  = (state_d == ST_PAYLOAD) || (state_d == ST_CHECK);
`else
      busy_d  = (state_d == ST_PAYLOAD);
`endif
   end

   // State and registered outputs; ready stays low for the edge on which reset is released.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         tile_ptr_q    <= 9'd0;
         remaining_q   <= 8'd0;
         ready_q       <= 1'b0;
         config_data_q <= 32'd0;
         config_en_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         err_code_q    <= 2'd0;
`ifdef CFG_CHECKSUM_EN
         csum_q        <= 32'd0;
`endif
      end else begin
         state_q       <= state_d;
         tile_ptr_q    <= tile_ptr_d;
         remaining_q   <= remaining_d;
         ready_q       <= ready_d;
         config_data_q <= config_data_d;
         config_en_q   <= config_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         err_code_q    <= err_code_d;
`ifdef CFG_CHECKSUM_EN
         csum_q        <= csum_d;
`endif
      end
   end

   assign cfg_in_ready = ready_q;
   assign config_data  = config_data_q;
   assign config_en    = config_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Table-driven bench for switch_box_config_loader (NUM_TILES=16), plus reset sequences.
module tb_switch_box_config_loader;

   localparam int NT = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   cfg_in_data;
   logic          cfg_in_valid;
   logic          cfg_in_ready;
   logic          err_clear;
   logic [31:0]   config_data;
   logic [NT-1:0] config_en;
   logic          busy;
   logic          done;
   logic          error;
   logic [1:0]    err_code;

   always #5 clk = ~clk;

   switch_box_config_loader #(.NUM_TILES(NT)) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_in_data  (cfg_in_data),
      .cfg_in_valid (cfg_in_valid),
      .cfg_in_ready (cfg_in_ready),
      .err_clear    (err_clear),
      .config_data  (config_data),
      .config_en    (config_en),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .err_code     (err_code)
   );

   typedef struct {
      string       name;
      logic        v;
      logic [31:0] d;
      logic        clr;
      logic [15:0] en;
      logic [31:0] cd;
      logic        rdy;
      logic        bsy;
      logic        dn;
      logic        err;
      logic [1:0]  code;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void add(input string n, input logic v, input logic [31:0] d, input logic c,
                               input logic [15:0] en, input logic [31:0] cd, input logic rdy,
                               input logic bsy, input logic dn, input logic err, input logic [1:0] code);
      vec_t t;
      t.name = n; t.v = v; t.d = d; t.clr = c; t.en = en; t.cd = cd;
      t.rdy = rdy; t.bsy = bsy; t.dn = dn; t.err = err; t.code = code;
      vq.push_back(t);
   endfunction

   function automatic logic [54:0] outs();
      return {config_en, config_data, cfg_in_ready, busy, done, error, err_code};
   endfunction

   task automatic check(input string name, input logic [54:0] act, input logic [54:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got en/data/rdy/busy/done/err/code=%h required %h", name, act, exp);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic c);
      @(negedge clk);
      cfg_in_valid = v;
      cfg_in_data  = d;
      err_clear    = c;
      @(posedge clk);
      #1;
   endtask

   task automatic run_table();
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].v, vq[i].d, vq[i].clr);
         check(vq[i].name, outs(), {vq[i].en, vq[i].cd, vq[i].rdy, vq[i].bsy,
                                    vq[i].dn, vq[i].err, vq[i].code});
      end
      drive(1'b0, 32'd0, 1'b0);
   endtask

   localparam logic [31:0] WA = 32'h1111_AAAA, WB = 32'h2222_BBBB;
   localparam logic [31:0] WX = 32'h3333_0014, WY = 32'h3333_0015, WZ = 32'h3333_0016;
   localparam logic [31:0] W0 = 32'h4000_0000, W1 = 32'h4000_0001, W2 = 32'h4000_0002, W3 = 32'h4000_0003;
   localparam logic [31:0] WV = 32'h5555_0001;
   localparam logic [31:0] H1 = 32'hC500_0101, D1 = 32'h0000_00D0, D2 = 32'h1234_5678;
   localparam logic [31:0] HR = 32'hC500_0F02, WP = 32'h6666_000F, WQ = 32'h6666_0010;

   logic [31:0] tr_s;

   initial begin
      reset        = 1'b0;
      cfg_in_valid = 1'b0;
      cfg_in_data  = 32'd0;
      err_clear    = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", outs(), 55'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_idle", outs(), {16'h0000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});

`ifndef CFG_CHECKSUM_EN
      //   name          v     data          clr   en        cd    rdy   bsy   dn    err   code
      add("p1_hdr",     1'b1, 32'hC500_0302, 1'b0, 16'h0000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p1_wA",      1'b1, WA,           1'b0, 16'h0008, WA,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p1_wB_done", 1'b1, WB,           1'b0, 16'h0010, WB,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      add("p1_idle",    1'b0, 32'd0,        1'b0, 16'h0000, WB,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add("p2_hdr",     1'b1, 32'hC500_0E03, 1'b0, 16'h0000, WB,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p2_t14",     1'b1, WX,           1'b0, 16'h4000, WX,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p2_t15",     1'b1, WY,           1'b0, 16'h8000, WY,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p2_t16_drop",1'b1, WZ,           1'b0, 16'h0000, WY,    1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      add("err_hold",   1'b1, 32'hC500_0001, 1'b0, 16'h0000, WY,    1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      add("err_clear1", 1'b0, 32'd0,        1'b1, 16'h0000, WY,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add("bad_magic",  1'b1, 32'hA500_0001, 1'b0, 16'h0000, WY,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      add("err_clear2", 1'b0, 32'd0,        1'b1, 16'h0000, WY,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add("p3_hdr",     1'b1, 32'hC500_0004, 1'b0, 16'h0000, WY,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p3_w0",      1'b1, W0,           1'b0, 16'h0001, W0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p3_bub0",    1'b0, 32'hFFFF_FFFF, 1'b0, 16'h0000, W0,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p3_w1",      1'b1, W1,           1'b0, 16'h0002, W1,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p3_bub1",    1'b0, 32'hFFFF_FFFF, 1'b0, 16'h0000, W1,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p3_w2",      1'b1, W2,           1'b0, 16'h0004, W2,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p3_bub2",    1'b0, 32'hFFFF_FFFF, 1'b0, 16'h0000, W2,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p3_w3_done", 1'b1, W3,           1'b0, 16'h0008, W3,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      add("p4_b2b_hdr", 1'b1, 32'hC500_0101, 1'b0, 16'h0000, W3,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("p4_w_done",  1'b1, WV,           1'b0, 16'h0002, WV,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      add("cnt0_done",  1'b1, 32'hC500_0000, 1'b0, 16'h0000, WV,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      add("clr_in_idle",1'b0, 32'd0,        1'b1, 16'h0000, WV,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
`else
      add("c1_hdr",     1'b1, H1,           1'b0, 16'h0000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("c1_wD",      1'b1, D1,           1'b0, 16'h0002, D1,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("c1_trl_ok",  1'b1, H1 ^ D1,      1'b0, 16'h0000, D1,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      add("c2_hdr",     1'b1, H1,           1'b0, 16'h0000, D1,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("c2_wD",      1'b1, D2,           1'b0, 16'h0002, D2,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("c2_trl_bad", 1'b1, H1 ^ D2 ^ 32'd1, 1'b0, 16'h0000, D2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      add("c2_clear",   1'b0, 32'd0,        1'b1, 16'h0000, D2,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add("c3_hdr_cnt0",1'b1, 32'hC500_0000, 1'b0, 16'h0000, D2,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("c3_trl_ok",  1'b1, 32'hC500_0000, 1'b0, 16'h0000, D2,    1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      add("c4_hdr",     1'b1, HR,           1'b0, 16'h0000, D2,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("c4_t15",     1'b1, WP,           1'b0, 16'h8000, WP,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
      add("c4_t16_drop",1'b1, WQ,           1'b0, 16'h0000, WP,    1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
      add("c4_trl_keep2",1'b1, HR ^ WP ^ WQ ^ 32'd1, 1'b0, 16'h0000, WP, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
      add("c4_clear",   1'b0, 32'd0,        1'b1, 16'h0000, WP,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      add("bad_magic",  1'b1, 32'hA500_0001, 1'b0, 16'h0000, WP,    1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
      add("err_clear",  1'b0, 32'd0,        1'b1, 16'h0000, WP,    1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
`endif
      run_table();

      // Reset dropped in between payload words of a 3-word packet to tiles 2..4.
      drive(1'b1, 32'hC500_0203, 1'b0);
      drive(1'b1, 32'hDEAD_0001, 1'b0);
      check("mid_w1", outs(), {16'h0004, 32'hDEAD_0001, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
      @(negedge clk);
      cfg_in_valid = 1'b1;
      cfg_in_data  = 32'hDEAD_0002;
      #2 reset = 1'b1;
      #1;
      check("mid_reset_async", outs(), 55'd0);
      @(negedge clk);
      reset       = 1'b0;
      cfg_in_data = H1;
      @(posedge clk);
      #1;
      check("release_no_xfer", outs(), {16'h0000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
      @(posedge clk);
      #1;
      check("post_reset_hdr", outs(), {16'h0000, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
`ifndef CFG_CHECKSUM_EN
      drive(1'b1, WV, 1'b0);
      check("post_reset_done", outs(), {16'h0002, WV, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
`else
      drive(1'b1, WV, 1'b0);
      check("post_reset_word", outs(), {16'h0002, WV, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
      tr_s = H1 ^ WV;
      drive(1'b1, tr_s, 1'b0);
      check("post_reset_done", outs(), {16'h0000, WV, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0});
`endif
      drive(1'b0, 32'd0, 1'b0);
      check("final_idle", outs(), {16'h0000, WV, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
